// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-gray converter family.
package gray_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY = 2'b00,
        MODE_EQUAL  = 2'b01,
        MODE_BT601  = 2'b10,
        MODE_PROG   = 2'b11
    } gray_mode_e;

    // Built-in weights, expressed as fractions of 2^8
    localparam int unsigned COEF_BASE_W  = 8;
    localparam int unsigned COEF_EQUAL   = 85;
    localparam int unsigned COEF_BT601_R = 77;
    localparam int unsigned COEF_BT601_G = 150;
    localparam int unsigned COEF_BT601_B = 29;

    // Legacy mode divides the plain channel sum by 4
    localparam int unsigned LEGACY_SHIFT = 2;

    // Rescale a built-in weight to a wider coefficient format
    function automatic int unsigned scale_coef(input int unsigned coef, input int unsigned coef_w);
        return coef << (coef_w - COEF_BASE_W);
    endfunction

endpackage

// File: rtl/rgb2gray_pipe_if.sv
// Pixel-in / gray-out streaming bus with per-pixel configuration.
interface rgb2gray_pipe_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_r;
    logic [PIX_W-1:0]  in_g;
    logic [PIX_W-1:0]  in_b;
    logic              in_sof;
    logic              in_eol;
    logic [1:0]        mode;
    logic [COEF_W-1:0] coef_r;
    logic [COEF_W-1:0] coef_g;
    logic [COEF_W-1:0] coef_b;
    logic              bin_en;
    logic [PIX_W-1:0]  thr;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_gray;
    logic              out_sof;
    logic              out_eol;

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_sof, in_eol,
        input  mode, coef_r, coef_g, coef_b, bin_en, thr, out_ready,
        output in_ready, out_valid, out_gray, out_sof, out_eol
    );

    modport master (
        output in_valid, in_r, in_g, in_b, in_sof, in_eol,
        output mode, coef_r, coef_g, coef_b, bin_en, thr, out_ready,
        input  in_ready, out_valid, out_gray, out_sof, out_eol
    );
endinterface

// File: rtl/gray_weight_mac.sv
// Three-way weighted sum of colour channels; purely combinational.
module gray_weight_mac #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 8
) (
    input  logic [PIX_W-1:0]          r_i,
    input  logic [PIX_W-1:0]          g_i,
    input  logic [PIX_W-1:0]          b_i,
    input  logic [COEF_W-1:0]         cr_i,
    input  logic [COEF_W-1:0]         cg_i,
    input  logic [COEF_W-1:0]         cb_i,
    output logic [PIX_W+COEF_W+1:0]   sum_o
);
    localparam int unsigned ACC_W = PIX_W + COEF_W + 2;

    logic [ACC_W-1:0] prod_r;
    logic [ACC_W-1:0] prod_g;
    logic [ACC_W-1:0] prod_b;

    always_comb begin
        prod_r = ACC_W'(r_i) * ACC_W'(cr_i);
        prod_g = ACC_W'(g_i) * ACC_W'(cg_i);
        prod_b = ACC_W'(b_i) * ACC_W'(cb_i);
        sum_o  = prod_r + prod_g + prod_b;
    end
endmodule

// File: rtl/rgb2gray_pipe.sv
// Three-stage RGB-to-gray converter with a single global stall and per-pixel configuration.
module rgb2gray_pipe
    import gray_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rgb2gray_pipe_if.slave   io
);
    localparam int unsigned ACC_W = PIX_W + COEF_W + 2;
    localparam int unsigned SCL_W = PIX_W + 2;
    localparam logic [COEF_W-1:0] EQ_C  = COEF_W'(scale_coef(COEF_EQUAL, COEF_W));
    localparam logic [COEF_W-1:0] R601_C = COEF_W'(scale_coef(COEF_BT601_R, COEF_W));
    localparam logic [COEF_W-1:0] G601_C = COEF_W'(scale_coef(COEF_BT601_G, COEF_W));
    localparam logic [COEF_W-1:0] B601_C = COEF_W'(scale_coef(COEF_BT601_B, COEF_W));
    localparam logic [ACC_W-1:0]  RND_C  = ACC_W'(ACC_W'(1) << (COEF_W - 1));

    logic adv;
    logic [COEF_W-1:0] cr_d, cg_d, cb_d;

    logic              s1_v_q, s1_leg_q, s1_bin_q, s1_sof_q, s1_eol_q;
    logic [PIX_W-1:0]  s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
    logic [COEF_W-1:0] s1_cr_q, s1_cg_q, s1_cb_q;

    logic              s2_v_q, s2_leg_q, s2_bin_q, s2_sof_q, s2_eol_q;
    logic [PIX_W-1:0]  s2_thr_q;
    logic [ACC_W-1:0]  s2_sum_d, s2_sum_q;

    logic              s3_v_q, s3_sof_q, s3_eol_q;
    logic [PIX_W-1:0]  s3_gray_d, s3_gray_q;
    logic [PIX_W-1:0]  base_gray;
    logic [SCL_W-1:0]  scaled;

    // Whole pipe moves together; out_ready reaches in_ready combinationally.
    assign adv         = io.out_ready | ~s3_v_q;
    assign io.in_ready = adv;

    // Legacy mode reuses the MAC with unit weights and a plain shift afterwards.
    always_comb begin
        cr_d = COEF_W'(1);
        cg_d = COEF_W'(1);
        cb_d = COEF_W'(1);
        unique case (gray_mode_e'(io.mode))
            MODE_EQUAL: begin cr_d = EQ_C;      cg_d = EQ_C;      cb_d = EQ_C;      end
            MODE_BT601: begin cr_d = R601_C;    cg_d = G601_C;    cb_d = B601_C;    end
            MODE_PROG:  begin cr_d = io.coef_r; cg_d = io.coef_g; cb_d = io.coef_b; end
            default:    ;
        endcase
    end

    gray_weight_mac #(.PIX_W(PIX_W), .COEF_W(COEF_W)) u_mac (
        .r_i   (s1_r_q),
        .g_i   (s1_g_q),
        .b_i   (s1_b_q),
        .cr_i  (s1_cr_q),
        .cg_i  (s1_cg_q),
        .cb_i  (s1_cb_q),
        .sum_o (s2_sum_d)
    );

    // Round, scale back to pixel range, saturate, then optional threshold.
    always_comb begin
        scaled    = SCL_W'((s2_sum_q + RND_C) >> COEF_W);
        base_gray = '0;
        if (s2_leg_q)
            base_gray = PIX_W'(s2_sum_q >> LEGACY_SHIFT);
        else if (|scaled[SCL_W-1:PIX_W])
            base_gray = '1;
        else
            base_gray = scaled[PIX_W-1:0];
        s3_gray_d = base_gray;
        if (s2_bin_q)
            s3_gray_d = (base_gray >= s2_thr_q) ? '1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0; s1_leg_q <= 1'b0; s1_bin_q <= 1'b0;
            s1_sof_q <= 1'b0; s1_eol_q <= 1'b0; s1_thr_q <= '0;
            s1_r_q   <= '0;   s1_g_q   <= '0;   s1_b_q   <= '0;
            s1_cr_q  <= '0;   s1_cg_q  <= '0;   s1_cb_q  <= '0;
            s2_v_q   <= 1'b0; s2_leg_q <= 1'b0; s2_bin_q <= 1'b0;
            s2_sof_q <= 1'b0; s2_eol_q <= 1'b0; s2_thr_q <= '0;
            s2_sum_q <= '0;
            s3_v_q   <= 1'b0; s3_sof_q <= 1'b0; s3_eol_q <= 1'b0;
            s3_gray_q <= '0;
        end else if (adv) begin
            s1_v_q   <= io.in_valid;
            s1_leg_q <= (gray_mode_e'(io.mode) == MODE_LEGACY);
            s1_bin_q <= io.bin_en;
            s1_thr_q <= io.thr;
            s1_sof_q <= io.in_sof;
            s1_eol_q <= io.in_eol;
            s1_r_q   <= io.in_r;
            s1_g_q   <= io.in_g;
            s1_b_q   <= io.in_b;
            s1_cr_q  <= cr_d;
            s1_cg_q  <= cg_d;
            s1_cb_q  <= cb_d;

            s2_v_q   <= s1_v_q;
            s2_leg_q <= s1_leg_q;
            s2_bin_q <= s1_bin_q;
            s2_thr_q <= s1_thr_q;
            s2_sof_q <= s1_sof_q;
            s2_eol_q <= s1_eol_q;
            s2_sum_q <= s2_sum_d;

            s3_v_q    <= s2_v_q;
            s3_sof_q  <= s2_sof_q;
            s3_eol_q  <= s2_eol_q;
            s3_gray_q <= s3_gray_d;
        end
    end

    assign io.out_valid = s3_v_q;
    assign io.out_gray  = s3_gray_q;
    assign io.out_sof   = s3_sof_q;
    assign io.out_eol   = s3_eol_q;
endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Self-checking bench: directed corner cases plus randomized streams against an arithmetic model.
module tb_rgb2gray_pipe;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] exp_q[$];          // {sof, eol, gray}
    bit   rnd_bp = 0;
    bit   stall_prev = 0;
    logic [7:0] gray_prev = '0;

    rgb2gray_pipe_if #(.PIX_W(8), .COEF_W(8)) bus ();
    rgb2gray_pipe #(.PIX_W(8), .COEF_W(8)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic straight from the weighting rules.
    function automatic logic [7:0] ref_gray(input int r, g, b, md, cr, cg, cb, input bit ben, input int th);
        int y;
        case (md)
            0:       y = (r + g + b) / 4;
            1:       y = (85 * (r + g + b) + 128) / 256;
            2:       y = (77 * r + 150 * g + 29 * b + 128) / 256;
            default: y = (cr * r + cg * g + cb * b + 128) / 256;
        endcase
        if (y > 255) y = 255;
        if (ben) y = (y >= th) ? 255 : 0;
        return 8'(y);
    endfunction

    // Output monitor: decides transfers from values stable at the falling edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (stall_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_gray", 32'(bus.out_gray), 32'(gray_prev));
        end
        stall_prev = rst_n && bus.out_valid && !bus.out_ready;
        gray_prev  = bus.out_gray;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out: got gray %0d expected no output", bus.out_gray);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_gray", 32'(bus.out_gray), 32'(e[7:0]));
                check("out_sof", 32'(bus.out_sof), 32'(e[9]));
                check("out_eol", 32'(bus.out_eol), 32'(e[8]));
            end
        end
    end

    task automatic cfg(input int md, cr, cg, cb, input bit ben, input int th);
        bus.mode   = 2'(md);
        bus.coef_r = 8'(cr);
        bus.coef_g = 8'(cg);
        bus.coef_b = 8'(cb);
        bus.bin_en = ben;
        bus.thr    = 8'(th);
    endtask

    // Offer one pixel until accepted; returns just after the accepting edge.
    task automatic send_px(input int r, g, b, input bit sof, eol);
        bit acc = 0;
        logic [7:0] eg;
        eg = ref_gray(r, g, b, int'(bus.mode), int'(bus.coef_r), int'(bus.coef_g),
                      int'(bus.coef_b), bus.bin_en, int'(bus.thr));
        bus.in_r = 8'(r); bus.in_g = 8'(g); bus.in_b = 8'(b);
        bus.in_sof = sof; bus.in_eol = eol; bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && !acc; i++) begin
            if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (acc) exp_q.push_back({sof, eol, eg});
        else check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Lone pixel through an empty pipe: latency and exact value.
    task automatic single(input string tag, input int r, g, b, input int exp_gray);
        int lat = 1;
        bit seen = 0;
        drain();
        send_px(r, g, b, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.out_valid) seen = 1;
            else begin @(posedge clk); #1; lat++; end
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, 32'(bus.out_gray), 32'(exp_gray));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        bus.in_sof = 1'b0; bus.in_eol = 1'b0; bus.out_ready = 1'b1;
        cfg(0, 0, 0, 0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_gray", 32'(bus.out_gray), 32'd0);
        check("rst_out_sof", 32'(bus.out_sof), 32'd0);
        check("rst_out_eol", 32'(bus.out_eol), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        cfg(0, 0, 0, 0, 1'b0, 0);
        single("legacy_white", 255, 255, 255, 191);
        single("legacy_444", 4, 4, 4, 3);
        cfg(2, 0, 0, 0, 1'b0, 0);
        single("bt601_white", 255, 255, 255, 255);
        single("bt601_red", 255, 0, 0, 77);
        single("bt601_green", 0, 255, 0, 149);
        single("bt601_blue", 0, 0, 255, 29);
        cfg(1, 0, 0, 0, 1'b0, 0);
        single("equal_white", 255, 255, 255, 254);
        cfg(3, 255, 255, 255, 1'b0, 0);
        single("prog_sat", 255, 255, 255, 255);
        cfg(3, 0, 0, 0, 1'b0, 0);
        single("prog_zero", 255, 255, 255, 0);
        cfg(2, 0, 0, 0, 1'b1, 100);
        single("bin_red", 255, 0, 0, 0);
        single("bin_green", 0, 255, 0, 255);
        drain();

        // Ten-pixel stream with a five-cycle downstream stall in the middle
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
            cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 1'b0, 0);
            send_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    i == 0, i == 9);
        end
        drain();

        // Mode toggled between back-to-back pixels
        for (int i = 0; i < 6; i++) begin
            cfg((i % 2 == 0) ? 0 : 2, 0, 0, 0, 1'b0, 0);
            send_px(200, 100, 50, i == 0, i == 5);
        end
        drain();

        // Random configuration and random backpressure
        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
            send_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_bp = 0;
        drain();

        // Reset with three pixels in flight
        cfg(2, 0, 0, 0, 1'b0, 0);
        send_px(10, 20, 30, 1'b1, 1'b0);
        send_px(40, 50, 60, 1'b0, 1'b0);
        send_px(70, 80, 90, 1'b0, 1'b1);
        check("inflight_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        cfg(0, 0, 0, 0, 1'b0, 0);
        single("post_rst_px", 8, 8, 8, 6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
